fbuff_port_arbiter: RTL and testbench

Owns the single BRAM port of frame_buffer and shares it between two clients: line_buffers, which reads whole rows during display, and a host tile-write interface. A host write updates one 12-bit tile inside a 48-bit row by read-modify-write. The block sits directly upstream of line_buffers and replaces the fixed init/DUT port mux. Display reads always win arbitration, so line fills are delayed by at most one RMW.

---
 rtl/fbuff_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_fbuff_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbuff_port_arbiter.sv
// fbuff_port_arbiter
// Owns the single frame_buffer BRAM port. line_buffers row reads always win
// arbitration; host tile writes are folded into the row by a
// read-modify-write of the 48-bit row that holds the tile.
module fbuff_port_arbiter #(
  parameter int PXL_WIDTH        = 12,
  parameter int TILE_PER_ROW     = 4,
  parameter int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH,
  parameter int FBUFF_DEPTH      = 4800,
  parameter int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH - 1),
  parameter int TOTAL_TILES      = 19200,
  parameter int TILE_ADDR_WIDTH  = $clog2(TOTAL_TILES)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rd_req_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                        rd_rsp_o,
  output logic [FBUFF_DATA_WIDTH-1:0] rd_data_o,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [TILE_ADDR_WIDTH-1:0]  wr_tile_addr_i,
  input  logic [PXL_WIDTH-1:0]        wr_pxl_i,
  output logic                        mem_ena_o,
  output logic                        mem_wea_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [FBUFF_DATA_WIDTH-1:0] mem_din_o,
  input  logic [FBUFF_DATA_WIDTH-1:0] mem_dout_i,
  output logic                        err_o
);

  localparam int LANE_WIDTH = (TILE_PER_ROW > 1) ? $clog2(TILE_PER_ROW) : 1;
  localparam logic [TILE_ADDR_WIDTH-1:0] TILE_LIMIT   = TILE_ADDR_WIDTH'(TOTAL_TILES);
  localparam logic [TILE_ADDR_WIDTH-1:0] TILES_IN_ROW = TILE_ADDR_WIDTH'(TILE_PER_ROW);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_RSP,
    RMW_RD,
    RMW_WAIT,
    RMW_WR
  } arbState_e;

  arbState_e r_state;
  arbState_e w_nextState;

  // Captured host write: the row/lane split is done once at accept time
  logic [FBUFF_ADDR_WIDTH-1:0] r_row;
  logic [LANE_WIDTH-1:0]       r_lane;
  logic [PXL_WIDTH-1:0]        r_pxl;

  // Registered outputs
  logic                        r_memEna;
  logic                        r_memWea;
  logic [FBUFF_ADDR_WIDTH-1:0] r_memAddr;
  logic [FBUFF_DATA_WIDTH-1:0] r_memDin;
  logic                        r_rdRsp;
  logic [FBUFF_DATA_WIDTH-1:0] r_rdData;
  logic                        r_err;

  // Next values for the registered outputs
  logic                        w_memEnaNext;
  logic                        w_memWeaNext;
  logic [FBUFF_ADDR_WIDTH-1:0] w_memAddrNext;
  logic [FBUFF_DATA_WIDTH-1:0] w_memDinNext;
  logic                        w_rdRspNext;
  logic [FBUFF_DATA_WIDTH-1:0] w_rdDataNext;
  logic                        w_errNext;

  logic                        w_idle;
  logic                        w_wrAccept;
  logic                        w_tileInRange;
  logic [FBUFF_ADDR_WIDTH-1:0] w_tileRow;
  logic [LANE_WIDTH-1:0]       w_tileLane;
  logic [FBUFF_DATA_WIDTH-1:0] w_merged;

  assign w_idle        = (r_state == IDLE);
  assign w_wrAccept    = w_idle && !rd_req_i && wr_valid_i;
  assign w_tileInRange = (wr_tile_addr_i < TILE_LIMIT);
  assign w_tileRow     = FBUFF_ADDR_WIDTH'(wr_tile_addr_i / TILES_IN_ROW);
  assign w_tileLane    = LANE_WIDTH'(wr_tile_addr_i % TILES_IN_ROW);

  // The host may only hand over a write when no display read is asking for the port;
  // gating with rstn keeps the flag low while the block is held in reset
  assign wr_ready_o = rstn && w_idle && !rd_req_i;

  assign mem_ena_o  = r_memEna;
  assign mem_wea_o  = r_memWea;
  assign mem_addr_o = r_memAddr;
  assign mem_din_o  = r_memDin;
  assign rd_rsp_o   = r_rdRsp;
  assign rd_data_o  = r_rdData;
  assign err_o      = r_err;

  // State register; reset abandons whatever read or RMW is in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: reads beat writes in IDLE, out-of-range tiles never leave IDLE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (rd_req_i) begin
          w_nextState = RD_ISSUE;
        end else if (wr_valid_i && w_tileInRange) begin
          w_nextState = RMW_RD;
        end
      end
      RD_ISSUE: w_nextState = RD_WAIT;
      RD_WAIT:  w_nextState = RD_RSP;
      RD_RSP:   w_nextState = IDLE;
      RMW_RD:   w_nextState = RMW_WAIT;
      RMW_WAIT: w_nextState = RMW_WR;
      RMW_WR:   w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Row read back from BRAM with the captured tile dropped into its lane
  always_comb begin
    w_merged = mem_dout_i;
    for (int lane = 0; lane < TILE_PER_ROW; lane++) begin
      if (r_lane == LANE_WIDTH'(lane)) begin
        w_merged[lane*PXL_WIDTH +: PXL_WIDTH] = r_pxl;
      end
    end
  end

  // Output decode: computed from the state being entered so the registered port lines up with it
  always_comb begin
    w_memEnaNext  = 1'b0;
    w_memWeaNext  = 1'b0;
    w_memAddrNext = r_memAddr;
    w_memDinNext  = r_memDin;
    w_rdRspNext   = 1'b0;
    w_rdDataNext  = r_rdData;
    w_errNext     = r_err;

    case (w_nextState)
      RD_ISSUE: begin
        w_memEnaNext  = 1'b1;
        w_memAddrNext = rd_addr_i;
      end
      RMW_RD: begin
        w_memEnaNext  = 1'b1;
        w_memAddrNext = w_tileRow;
      end
      RMW_WR: begin
        w_memEnaNext  = 1'b1;
        w_memWeaNext  = 1'b1;
        w_memAddrNext = r_row;
      end
      RD_RSP: begin
        w_rdRspNext = 1'b1;
      end
      default: begin
        w_memEnaNext = 1'b0;
      end
    endcase

    if (r_state == RD_WAIT) begin
      w_rdDataNext = mem_dout_i;
    end
    if (r_state == RMW_WAIT) begin
      w_memDinNext = w_merged;
    end

    if (w_wrAccept && !w_tileInRange) begin
      w_errNext = 1'b1;
    end
    if (((r_state == RD_ISSUE) || (r_state == RD_WAIT)) && !rd_req_i) begin
      w_errNext = 1'b1;
    end
  end

  // Capture the accepted host write so the RMW works from stable values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_row  <= '0;
      r_lane <= '0;
      r_pxl  <= '0;
    end else if (w_wrAccept && w_tileInRange) begin
      r_row  <= w_tileRow;
      r_lane <= w_tileLane;
      r_pxl  <= wr_pxl_i;
    end
  end

  // Register every BRAM-side and response output; address, data and error hold between updates
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_memEna  <= 1'b0;
      r_memWea  <= 1'b0;
      r_memAddr <= '0;
      r_memDin  <= '0;
      r_rdRsp   <= 1'b0;
      r_rdData  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_memEna  <= w_memEnaNext;
      r_memWea  <= w_memWeaNext;
      r_memAddr <= w_memAddrNext;
      r_memDin  <= w_memDinNext;
      r_rdRsp   <= w_rdRspNext;
      r_rdData  <= w_rdDataNext;
      r_err     <= w_errNext;
    end
  end

endmodule

// File: tb/tb_fbuff_port_arbiter.sv
// tb_fbuff_port_arbiter
// Directed bench for the frame buffer port arbiter with a BRAM model, a
// transaction-level timeline model of the expected port activity, and
// hand-computed literal checks for the key scenarios.
module tb_fbuff_port_arbiter;

  localparam int PW    = 12;
  localparam int DW    = 48;
  localparam int AW    = 13;
  localparam int TW    = 15;
  localparam int DEPTH = 4800;
  localparam int TILES = 19200;
  localparam int NEVER = 32'h7fffffff;

  logic          clk;
  logic          rstn;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_rsp_o;
  logic [DW-1:0] rd_data_o;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [TW-1:0] wr_tile_addr_i;
  logic [PW-1:0] wr_pxl_i;
  logic          mem_ena_o;
  logic          mem_wea_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_din_o;
  logic [DW-1:0] memDout;
  logic          err_o;

  fbuff_port_arbiter dut (
    .clk            (clk),
    .rstn           (rstn),
    .rd_req_i       (rd_req_i),
    .rd_addr_i      (rd_addr_i),
    .rd_rsp_o       (rd_rsp_o),
    .rd_data_o      (rd_data_o),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_tile_addr_i (wr_tile_addr_i),
    .wr_pxl_i       (wr_pxl_i),
    .mem_ena_o      (mem_ena_o),
    .mem_wea_o      (mem_wea_o),
    .mem_addr_o     (mem_addr_o),
    .mem_din_o      (mem_din_o),
    .mem_dout_i     (memDout),
    .err_o          (err_o)
  );

  typedef struct packed {
    bit          ena;
    bit          wea;
    bit          rsp;
    bit [AW-1:0] addr;
    bit [DW-1:0] din;
    bit [DW-1:0] data;
  } expT;

  expT           expTab [4096];
  logic [DW-1:0] bram   [DEPTH];
  logic [DW-1:0] refMem [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Timeline model state: when the port is next free, when err must be high,
  // the start cycle of the latest read, and a write waiting to land in refMem
  int            freeAt  = 0;
  int            errFrom = NEVER;
  int            rdStart = -100;
  int            pendAt  = -1;
  logic [AW-1:0] pendRow;
  logic [DW-1:0] pendVal;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, read by the compare process on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous BRAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_ena_o) begin
      if (mem_wea_o) bram[mem_addr_o] <= mem_din_o;
      else           memDout <= bram[mem_addr_o];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic [AW-1:0] ra, input logic wv,
                               input logic [TW-1:0] ta, input logic [PW-1:0] px);
    rd_req_i       = rq;
    rd_addr_i      = ra;
    wr_valid_i     = wv;
    wr_tile_addr_i = ta;
    wr_pxl_i       = px;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preloadRow(input logic [AW-1:0] row, input logic [DW-1:0] val);
    bram[row]   <= val;
    refMem[row]  = val;
  endtask

  // Host tile write issued from an IDLE cycle; returns in the next IDLE cycle
  task automatic hostWrite(input logic [TW-1:0] tile, input logic [PW-1:0] px);
    applyStimulus(1'b0, '0, 1'b1, tile, px);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    repeat (3) nextCycle();
  endtask

  // Row read issued from an IDLE cycle with a literal expected row; returns in the next IDLE cycle
  task automatic rowRead(input logic [AW-1:0] row, input logic [DW-1:0] exp, input string name);
    applyStimulus(1'b1, row, 1'b0, '0, '0);
    repeat (3) nextCycle();
    checkOutput({name, " rd_rsp_o"}, 64'(rd_rsp_o), 64'd1);
    checkOutput({name, " rd_data_o"}, 64'(rd_data_o), 64'(exp));
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    nextCycle();
  endtask

  // Compare process and timeline model, evaluated mid-cycle
  always @(negedge clk) begin : cmp
    expT           e;
    int            t;
    logic [AW-1:0] row;
    logic [1:0]    lane;
    if (!rstn) begin
      checkOutput("rst mem_ena_o", 64'(mem_ena_o), 64'd0);
      checkOutput("rst mem_wea_o", 64'(mem_wea_o), 64'd0);
      checkOutput("rst rd_rsp_o", 64'(rd_rsp_o), 64'd0);
      checkOutput("rst err_o", 64'(err_o), 64'd0);
      checkOutput("rst wr_ready_o", 64'(wr_ready_o), 64'd0);
      for (int k = 0; k < 8; k++) begin
        t = cyc + k;
        expTab[t[11:0]] = '0;
      end
      freeAt  = cyc + 1;
      errFrom = NEVER;
      rdStart = -100;
      pendAt  = -1;
    end else begin
      t = cyc;
      e = expTab[t[11:0]];
      expTab[t[11:0]] = '0;
      if (pendAt == cyc) refMem[pendRow] = pendVal;

      checkOutput("wr_ready_o", 64'(wr_ready_o), 64'((cyc >= freeAt) && !rd_req_i));
      checkOutput("mem_ena_o", 64'(mem_ena_o), 64'(e.ena));
      checkOutput("mem_wea_o", 64'(mem_wea_o), 64'(e.wea));
      checkOutput("rd_rsp_o", 64'(rd_rsp_o), 64'(e.rsp));
      checkOutput("err_o", 64'(err_o), 64'(cyc >= errFrom));
      if (e.ena) checkOutput("mem_addr_o", 64'(mem_addr_o), 64'(e.addr));
      if (e.wea) checkOutput("mem_din_o", 64'(mem_din_o), 64'(e.din));
      if (e.rsp) checkOutput("rd_data_o", 64'(rd_data_o), 64'(e.data));

      // A read request must stay up for the two cycles after it was taken
      if (((cyc == rdStart + 1) || (cyc == rdStart + 2)) && !rd_req_i && (errFrom > cyc + 1))
        errFrom = cyc + 1;

      if (cyc >= freeAt) begin
        if (rd_req_i) begin
          rdStart = cyc;
          row     = rd_addr_i;
          t = cyc + 1;
          expTab[t[11:0]].ena  = 1'b1;
          expTab[t[11:0]].addr = row;
          t = cyc + 3;
          expTab[t[11:0]].rsp  = 1'b1;
          expTab[t[11:0]].data = refMem[row];
          freeAt = cyc + 4;
        end else if (wr_valid_i) begin
          if (int'(wr_tile_addr_i) >= TILES) begin
            if (errFrom > cyc + 1) errFrom = cyc + 1;
          end else begin
            row     = AW'(wr_tile_addr_i / 4);
            lane    = 2'(wr_tile_addr_i % 4);
            pendRow = row;
            pendVal = (refMem[row] & ~(48'hFFF << (lane * PW))) | (48'(wr_pxl_i) << (lane * PW));
            pendAt  = cyc + 3;
            t = cyc + 1;
            expTab[t[11:0]].ena  = 1'b1;
            expTab[t[11:0]].addr = row;
            t = cyc + 3;
            expTab[t[11:0]].ena  = 1'b1;
            expTab[t[11:0]].wea  = 1'b1;
            expTab[t[11:0]].addr = row;
            expTab[t[11:0]].din  = pendVal;
            freeAt = cyc + 4;
          end
        end
      end
    end
  end

  // Safety net in case the DUT or bench stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin : stim
    logic [AW-1:0] r;
    int            n;
    rstn = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      r = AW'(i);
      preloadRow(r, {4{PW'(i)}});
    end
    preloadRow(13'd5, 48'h123456789ABC);
    preloadRow(13'd10, 48'h000000000000);
    preloadRow(13'd4799, 48'hABCDEF012345);
    rstn = 1'b0;

    repeat (3) nextCycle();
    checkOutput("reset rd_data_o", 64'(rd_data_o), 64'd0);
    checkOutput("reset mem_addr_o", 64'(mem_addr_o), 64'd0);
    checkOutput("reset mem_din_o", 64'(mem_din_o), 64'd0);
    rstn = 1'b1;
    #1;
    checkOutput("idle wr_ready_o", 64'(wr_ready_o), 64'd1);
    nextCycle();

    // Uncontended read of row 5
    applyStimulus(1'b1, 13'd5, 1'b0, '0, '0);
    nextCycle();
    checkOutput("read ena", 64'(mem_ena_o), 64'd1);
    checkOutput("read addr", 64'(mem_addr_o), 64'd5);
    checkOutput("read early rsp", 64'(rd_rsp_o), 64'd0);
    nextCycle();
    checkOutput("read wait ena", 64'(mem_ena_o), 64'd0);
    nextCycle();
    checkOutput("read rsp", 64'(rd_rsp_o), 64'd1);
    checkOutput("read data", 64'(rd_data_o), 64'h123456789ABC);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    nextCycle();
    checkOutput("read rsp one-shot", 64'(rd_rsp_o), 64'd0);

    // Tile 42 -> row 10 lane 2
    applyStimulus(1'b0, '0, 1'b1, 15'd42, 12'hF0A);
    checkOutput("write ready", 64'(wr_ready_o), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("rmw rd ready", 64'(wr_ready_o), 64'd0);
    checkOutput("rmw rd addr", 64'(mem_addr_o), 64'd10);
    checkOutput("rmw rd wea", 64'(mem_wea_o), 64'd0);
    nextCycle();
    checkOutput("rmw wait ready", 64'(wr_ready_o), 64'd0);
    nextCycle();
    checkOutput("rmw wr ready", 64'(wr_ready_o), 64'd0);
    checkOutput("rmw wr wea", 64'(mem_wea_o), 64'd1);
    checkOutput("rmw wr din", 64'(mem_din_o), 64'h000F0A000000);
    nextCycle();
    checkOutput("rmw done ready", 64'(wr_ready_o), 64'd1);

    // Read and write in the same IDLE cycle: read first, write held
    applyStimulus(1'b1, 13'd10, 1'b1, 15'd5, 12'h123);
    checkOutput("contend ready", 64'(wr_ready_o), 64'd0);
    repeat (3) nextCycle();
    checkOutput("contend rsp", 64'(rd_rsp_o), 64'd1);
    checkOutput("contend data", 64'(rd_data_o), 64'h000F0A000000);
    applyStimulus(1'b0, 13'd10, 1'b1, 15'd5, 12'h123);
    checkOutput("contend rsp ready", 64'(wr_ready_o), 64'd0);
    nextCycle();
    checkOutput("contend write ready", 64'(wr_ready_o), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    nextCycle();
    // Read raised in RMW_WAIT: RMW_WR +1, IDLE samples it +2, response lands +5
    applyStimulus(1'b1, 13'd1, 1'b0, '0, '0);
    n = 0;
    while (!rd_rsp_o && n < 10) begin
      nextCycle();
      n++;
    end
    checkOutput("read behind rmw latency", 64'(n), 64'd5);
    checkOutput("read behind rmw data", 64'(rd_data_o), 64'h001001123001);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    nextCycle();

    // Last tile of the frame, then read its row back
    hostWrite(15'd19199, 12'h777);
    rowRead(13'd4799, 48'h777DEF012345, "coherency");

    // Tile index past the frame: accepted, flagged, no port activity
    applyStimulus(1'b0, '0, 1'b1, 15'd19200, 12'hFFF);
    checkOutput("bad tile ready", 64'(wr_ready_o), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("bad tile err", 64'(err_o), 64'd1);
    checkOutput("bad tile ena", 64'(mem_ena_o), 64'd0);
    nextCycle();
    checkOutput("bad tile ena later", 64'(mem_ena_o), 64'd0);

    // Reset in RMW_WAIT of a write to row 10 lane 0
    applyStimulus(1'b0, '0, 1'b1, 15'd40, 12'hABC);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    nextCycle();
    rstn = 1'b0;
    #1;
    checkOutput("mid-rmw reset ena", 64'(mem_ena_o), 64'd0);
    checkOutput("mid-rmw reset addr", 64'(mem_addr_o), 64'd0);
    checkOutput("mid-rmw reset din", 64'(mem_din_o), 64'd0);
    checkOutput("mid-rmw reset err", 64'(err_o), 64'd0);
    checkOutput("mid-rmw reset ready", 64'(wr_ready_o), 64'd0);
    nextCycle();
    rstn = 1'b1;
    #1;
    checkOutput("post reset ready", 64'(wr_ready_o), 64'd1);
    rowRead(13'd10, 48'h000F0A000000, "abandoned rmw");

    // Read request dropped in RD_WAIT
    applyStimulus(1'b1, 13'd5, 1'b0, '0, '0);
    nextCycle();
    checkOutput("drop err before", 64'(err_o), 64'd0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    nextCycle();
    checkOutput("drop err", 64'(err_o), 64'd1);
    checkOutput("drop rsp", 64'(rd_rsp_o), 64'd1);
    checkOutput("drop data", 64'(rd_data_o), 64'h123456789ABC);
    nextCycle();
    checkOutput("drop rsp one-shot", 64'(rd_rsp_o), 64'd0);
    checkOutput("drop err sticky", 64'(err_o), 64'd1);

    repeat (3) nextCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
